right_shift_seq: RTL and testbench

Sequential right shifter for the 16-bit datapath, the inverse of the fixed left-shift-by-2 used for address/offset scaling. It takes a 16-bit operand and a 4-bit shift amount, then shifts one bit position per clock, logical or arithmetic. Results are reported with a start/busy/done handshake. It sits beside the ALU as a multi-cycle unit and is driven by the control FSM.

---
 rtl/right_shift_seq.sv | 92 +++++++++
 tb/tb_right_shift_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/right_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : right_shift_seq
// Brief    : Multi-cycle logical/arithmetic right shifter, one bit per clock,
//            with a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module right_shift_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] amount,
    input  logic             arith,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] C_CNT_LAST = AMT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;

    // busy/done are registered alongside each state transition so they
    // never depend combinationally on the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data <= in;
                        r_cnt  <= amount;
                        r_mode <= arith;
                        r_busy <= 1'b1;
                        if (amount != '0) begin
                            r_state <= S_SHIFT;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data <= {r_mode & r_data[WIDTH-1], r_data[WIDTH-1:1]};
                    r_cnt  <= r_cnt - C_CNT_LAST;
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_data;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_right_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_right_shift_seq
// Brief    : Directed self-checking bench for right_shift_seq.
// Revision : 1.0
// ============================================================================
module tb_right_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in;
    logic [3:0]  amount;
    logic        arith;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int vectors    = 0;
    int miscompares = 0;

    right_shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in),
        .amount (amount),
        .arith  (arith),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge; sample 1 time unit in.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in = 16'hFFFF; amount = 4'd3; arith = 1'b1;
        tick(); tick();
        vectors++;
        if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h busy=%b done=%b, want out=0000 busy=0 done=0", out, busy, done);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: out=%h busy=%b done=%b, want out=0000 busy=0 done=0", out, busy, done);
        end
    endtask

    task automatic test_logical();
        in = 16'h8000; amount = 4'd2; arith = 1'b0; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            vectors++;
            if (done !== (c == 3) || busy !== (c <= 3)) begin
                miscompares++;
                $display("FAIL logical_hs c%0d: done=%b busy=%b, want done=%b busy=%b", c, done, busy, c == 3, c <= 3);
            end
            if (c == 2) begin
                vectors++;
                if (out !== 16'h4000) begin
                    miscompares++;
                    $display("FAIL logical_mid: out=%h, want 4000", out);
                end
            end
            if (c == 3 || c == 4) begin
                vectors++;
                if (out !== 16'h2000) begin
                    miscompares++;
                    $display("FAIL logical_result c%0d: out=%h, want 2000", c, out);
                end
            end
        end
    endtask

    task automatic test_arith();
        logic [15:0] ops [2] = '{16'h8000, 16'h4000};
        logic [15:0] exps[2] = '{16'hE000, 16'h1000};
        for (int v = 0; v < 2; v++) begin
            in = ops[v]; amount = 4'd2; arith = 1'b1; start = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                tick();
                start = 1'b0;
                vectors++;
                if (done !== (c == 3) || busy !== (c <= 3)) begin
                    miscompares++;
                    $display("FAIL arith_hs v%0d c%0d: done=%b busy=%b, want done=%b busy=%b", v, c, done, busy, c == 3, c <= 3);
                end
                if (c == 3) begin
                    vectors++;
                    if (out !== exps[v]) begin
                        miscompares++;
                        $display("FAIL arith_result v%0d: out=%h, want %h", v, out, exps[v]);
                    end
                end
            end
        end
    endtask

    task automatic test_amount_bounds();
        logic [15:0] ops [3] = '{16'h1234, 16'h8001, 16'h8001};
        logic [3:0]  amts[3] = '{4'd0, 4'd15, 4'd15};
        logic        ars [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] exps[3] = '{16'h1234, 16'hFFFF, 16'h0001};
        int dc;
        for (int v = 0; v < 3; v++) begin
            in = ops[v]; amount = amts[v]; arith = ars[v]; start = 1'b1;
            dc = int'(amts[v]) + 1;
            for (int c = 1; c <= dc + 1; c++) begin
                tick();
                start = 1'b0;
                vectors++;
                if (done !== (c == dc) || busy !== (c <= dc)) begin
                    miscompares++;
                    $display("FAIL bounds_hs v%0d c%0d: done=%b busy=%b, want done=%b busy=%b", v, c, done, busy, c == dc, c <= dc);
                end
                if (c == dc) begin
                    vectors++;
                    if (out !== exps[v]) begin
                        miscompares++;
                        $display("FAIL bounds_result v%0d: out=%h, want %h", v, out, exps[v]);
                    end
                end
            end
        end
    endtask

    task automatic test_busy_protect();
        logic exp_done, exp_busy;
        in = 16'h00F0; amount = 4'd4; arith = 1'b0; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp_done = (c == 5) || (c == 8);
            exp_busy = (c <= 5) || (c == 7) || (c == 8);
            vectors++;
            if (done !== exp_done || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy_protect_hs c%0d: done=%b busy=%b, want done=%b busy=%b", c, done, busy, exp_done, exp_busy);
            end
            if (c == 5) begin
                vectors++;
                if (out !== 16'h000F) begin
                    miscompares++;
                    $display("FAIL busy_protect_first: out=%h, want 000F", out);
                end
            end
            if (c == 8) begin
                vectors++;
                if (out !== 16'h7FFF) begin
                    miscompares++;
                    $display("FAIL busy_protect_reaccept: out=%h, want 7FFF", out);
                end
            end
            // Pulse in cycle 2; hold from the DONE cycle (5) through IDLE (6).
            if (c == 2 || c == 5) begin
                start = 1'b1; in = 16'hFFFF; amount = 4'd1;
            end else if (c == 3 || c == 7) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        in = 16'hFF00; amount = 4'd8; arith = 1'b0; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            vectors++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mid_pre c%0d: done=%b busy=%b, want done=0 busy=1", c, done, busy);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: out=%h busy=%b done=%b, want out=0000 busy=0 done=0", out, busy, done);
        end
        in = 16'h0002; amount = 4'd1; arith = 1'b0; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = 1'b0;
            vectors++;
            if (done !== (c == 2) || busy !== (c <= 2)) begin
                miscompares++;
                $display("FAIL reset_mid_restart c%0d: done=%b busy=%b, want done=%b busy=%b", c, done, busy, c == 2, c <= 2);
            end
            if (c == 2) begin
                vectors++;
                if (out !== 16'h0001) begin
                    miscompares++;
                    $display("FAIL reset_mid_result: out=%h, want 0001", out);
                end
            end
        end
    endtask

    task automatic test_operand_change();
        in = 16'hB000; amount = 4'd3; arith = 1'b1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start  = 1'b0;
            in     = 16'(c * 16'h1111);
            amount = 4'(c + 7);
            arith  = c[0];
            vectors++;
            if (done !== (c == 4) || busy !== (c <= 4)) begin
                miscompares++;
                $display("FAIL operand_change_hs c%0d: done=%b busy=%b, want done=%b busy=%b", c, done, busy, c == 4, c <= 4);
            end
            if (c == 4) begin
                vectors++;
                if (out !== 16'hF600) begin
                    miscompares++;
                    $display("FAIL operand_change_result: out=%h, want F600", out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_amount_bounds();
        test_busy_protect();
        test_reset_mid();
        test_operand_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
